trig_dispatcher: RTL and testbench

TRIG_DISPATCHER -- requirements
Module: trig_dispatcher

---
 rtl/trig_dispatcher.sv | 107 ++++++++++
 tb/tb_trig_dispatcher.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_dispatcher.sv
// Trigger-in capture with round-robin command dispatch and a one-command handshake.
// Optional abort timeout is built only when TRIG_DISPATCH_TIMEOUT_EN is defined.
module trig_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        ep_clk,
    input  logic        ti_reset,
    input  logic [15:0] ep_trigger,
    input  logic [15:0] trig_mask,
    input  logic        cmd_ack,
    input  logic        status_clear,
    output logic        cmd_valid,
    output logic [3:0]  cmd_id,
    output logic [15:0] pending,
    output logic [15:0] overrun,
    output logic        timeout_flag,
    output logic        busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("trig_dispatcher: TIMEOUT_CYCLES out of range 2..65535");
    end

    logic [0:0]  state;
    logic [3:0]  last_grant;
    logic [15:0] cap;
    logic [15:0] clr;
    logic        ack;
    logic        tmo;
    logic        done;
    logic [3:0]  pick;

    assign cap  = ep_trigger & ~trig_mask;
    assign ack  = (state == S_ISSUE) && cmd_ack;
    assign done = ack || tmo;
    assign clr  = done ? (16'h0001 << cmd_id) : 16'h0000;
    assign busy = (state == S_ISSUE);

`ifdef TRIG_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
    // ack in the final cycle takes precedence over the abort
    assign tmo = (state == S_ISSUE) && !cmd_ack && (cnt == TO_LAST);
`else
    assign tmo = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Scan from highest offset down so the last hit is the first set bit after last_grant.
    always_comb begin
        logic [3:0] idx;
        pick = last_grant;
        idx  = last_grant;
        for (int k = 16; k >= 1; k--) begin
            idx = last_grant + 4'(k);
            if (pending[idx]) pick = idx;
        end
    end

    always_ff @(posedge ep_clk) begin
        if (ti_reset) begin
            state      <= S_IDLE;
            cmd_valid  <= 1'b0;
            cmd_id     <= 4'd0;
            pending    <= 16'h0000;
            overrun    <= 16'h0000;
            last_grant <= 4'd15;
        end else begin
            // A trigger on the bit being retired re-arms it instead of overrunning.
            pending <= (pending & ~clr) | cap;
            overrun <= (status_clear ? 16'h0000 : overrun) | (cap & pending & ~clr);
            case (state)
                S_IDLE: begin
                    if (pending != 16'h0000) begin
                        state     <= S_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_id    <= pick;
                    end
                end
                default: begin
                    if (done) begin
                        state      <= S_IDLE;
                        cmd_valid  <= 1'b0;
                        last_grant <= cmd_id;
                    end
                end
            endcase
        end
    end

`ifdef TRIG_DISPATCH_TIMEOUT_EN
    always_ff @(posedge ep_clk) begin
        if (ti_reset) begin
            cnt          <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= (status_clear ? 1'b0 : timeout_flag) | tmo;
            if (state == S_IDLE) cnt <= 16'd0;
            else                 cnt <= cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trig_dispatcher.sv
// Directed bench for trig_dispatcher; timeout checks follow TRIG_DISPATCH_TIMEOUT_EN.
module tb_trig_dispatcher;

    logic        ep_clk = 1'b0;
    logic        ti_reset = 1'b1;
    logic [15:0] ep_trigger = '0;
    logic [15:0] trig_mask = '0;
    logic        cmd_ack = 1'b0;
    logic        status_clear = 1'b0;
    logic        cmd_valid;
    logic [3:0]  cmd_id;
    logic [15:0] pending;
    logic [15:0] overrun;
    logic        timeout_flag;
    logic        busy;

    int checks = 0;
    int passed = 0;

    trig_dispatcher #(.TIMEOUT_CYCLES(4)) dut (
        .ep_clk(ep_clk), .ti_reset(ti_reset), .ep_trigger(ep_trigger),
        .trig_mask(trig_mask), .cmd_ack(cmd_ack), .status_clear(status_clear),
        .cmd_valid(cmd_valid), .cmd_id(cmd_id), .pending(pending),
        .overrun(overrun), .timeout_flag(timeout_flag), .busy(busy)
    );

    always #5 ep_clk = ~ep_clk;

    task automatic step();
        @(posedge ep_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        ti_reset = 1'b1;
        step();
        ti_reset = 1'b0;
    endtask

    // Check the presented command, ack it, and confirm it drops the next cycle.
    task automatic expect_issue(input string tag, input logic [3:0] id);
        chk({tag, "_valid"}, 16'(cmd_valid), 16'd1);
        chk({tag, "_id"}, 16'(cmd_id), 16'(id));
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk({tag, "_drop"}, 16'(cmd_valid), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a trigger present: it must be discarded
        ep_trigger = 16'h0001;
        step();
        step();
        ti_reset = 1'b0;
        ep_trigger = 16'h0000;
        step();
        chk("rst_valid", 16'(cmd_valid), 16'd0);
        chk("rst_id", 16'(cmd_id), 16'd0);
        chk("rst_pending", pending, 16'h0000);
        chk("rst_overrun", overrun, 16'h0000);
        chk("rst_tflag", 16'(timeout_flag), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);

        // single trigger: latency 2, stable until ack
        ep_trigger = 16'h0010;
        step();
        ep_trigger = 16'h0000;
        chk("single_pend", pending, 16'h0010);
        chk("single_notyet", 16'(cmd_valid), 16'd0);
        step();
        chk("single_v7", 16'(cmd_valid), 16'd1);
        chk("single_id7", 16'(cmd_id), 16'd4);
        chk("single_busy", 16'(busy), 16'd1);
        step();
        chk("single_id8", 16'(cmd_id), 16'd4);
        step();
        chk("single_v9", 16'(cmd_valid), 16'd1);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk("single_v10", 16'(cmd_valid), 16'd0);
        chk("single_pend10", pending, 16'h0000);
        chk("single_idhold", 16'(cmd_id), 16'd4);
        chk("single_busy10", 16'(busy), 16'd0);

        // round robin from reset priority
        do_reset();
        ep_trigger = 16'h8003;
        step();
        ep_trigger = 16'h0000;
        step();
        expect_issue("rr0", 4'd0);
        step();
        expect_issue("rr1", 4'd1);
        step();
        expect_issue("rr15", 4'd15);
        ep_trigger = 16'h0003;
        step();
        ep_trigger = 16'h0000;
        step();
        expect_issue("rr_wrap0", 4'd0);
        step();
        expect_issue("rr_wrap1", 4'd1);

        // overrun and coalescing on bit 2
        ep_trigger = 16'h0004;
        step();
        step();
        step();
        ep_trigger = 16'h0000;
        chk("ovr_flag", overrun, 16'h0004);
        chk("ovr_pend", pending, 16'h0004);
        expect_issue("ovr_cmd", 4'd2);
        chk("ovr_pend_clr", pending, 16'h0000);
        step();
        chk("ovr_single1", 16'(cmd_valid), 16'd0);
        step();
        chk("ovr_single2", 16'(cmd_valid), 16'd0);
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        chk("ovr_cleared", overrun, 16'h0000);

        // trigger on the granted bit in its ack cycle re-arms without overrun
        ep_trigger = 16'h0020;
        step();
        ep_trigger = 16'h0000;
        step();
        chk("sim_id", 16'(cmd_id), 16'd5);
        cmd_ack = 1'b1;
        ep_trigger = 16'h0020;
        step();
        cmd_ack = 1'b0;
        ep_trigger = 16'h0000;
        chk("sim_pend", pending, 16'h0020);
        chk("sim_novr", overrun, 16'h0000);
        chk("sim_drop", 16'(cmd_valid), 16'd0);
        step();
        expect_issue("sim_again", 4'd5);
        chk("sim_pend0", pending, 16'h0000);

        // mask blocks capture only
        trig_mask = 16'h00FF;
        ep_trigger = 16'h0101;
        step();
        ep_trigger = 16'h0000;
        chk("mask_pend", pending, 16'h0100);
        step();
        expect_issue("mask_cmd", 4'd8);
        chk("mask_pend0", pending, 16'h0000);
        step();
        chk("mask_only", 16'(cmd_valid), 16'd0);
        trig_mask = 16'h0000;
        ep_trigger = 16'h0200;
        step();
        ep_trigger = 16'h0000;
        trig_mask = 16'hFFFF;
        step();
        expect_issue("mask_late", 4'd9);
        trig_mask = 16'h0000;

        // status_clear coinciding with a new overrun: set wins
        ep_trigger = 16'h0080;
        step();
        status_clear = 1'b1;
        step();
        ep_trigger = 16'h0000;
        status_clear = 1'b0;
        chk("clr_setwins", overrun, 16'h0080);
        expect_issue("clr_cmd", 4'd7);
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        chk("clr_done", overrun, 16'h0000);

        // reset mid-issue
        ep_trigger = 16'h0006;
        step();
        ep_trigger = 16'h0000;
        step();
        chk("rmid_valid", 16'(cmd_valid), 16'd1);
        chk("rmid_pend", pending, 16'h0006);
        ti_reset = 1'b1;
        step();
        ti_reset = 1'b0;
        chk("rmid_v0", 16'(cmd_valid), 16'd0);
        chk("rmid_p0", pending, 16'h0000);
        chk("rmid_tf", 16'(timeout_flag), 16'd0);
        chk("rmid_busy", 16'(busy), 16'd0);
        ep_trigger = 16'h0006;
        step();
        ep_trigger = 16'h0000;
        step();
        expect_issue("rmid_first", 4'd1);
        step();
        expect_issue("rmid_second", 4'd2);

`ifdef TRIG_DISPATCH_TIMEOUT_EN
        // no ack: four valid cycles then abort
        ep_trigger = 16'h0008;
        step();
        ep_trigger = 16'h0000;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("to_valid%0d", c), 16'(cmd_valid), 16'd1);
        end
        step();
        chk("to_drop", 16'(cmd_valid), 16'd0);
        chk("to_flag", 16'(timeout_flag), 16'd1);
        chk("to_pend", pending, 16'h0000);
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        chk("to_clr", 16'(timeout_flag), 16'd0);
        // ack in the final cycle wins
        ep_trigger = 16'h0008;
        step();
        ep_trigger = 16'h0000;
        step();
        step();
        step();
        step();
        chk("toack_v4", 16'(cmd_valid), 16'd1);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk("toack_drop", 16'(cmd_valid), 16'd0);
        chk("toack_flag", 16'(timeout_flag), 16'd0);
`else
        // without the timeout a command waits indefinitely
        ep_trigger = 16'h0008;
        step();
        ep_trigger = 16'h0000;
        for (int c = 1; c <= 8; c++) step();
        chk("hold_valid", 16'(cmd_valid), 16'd1);
        chk("hold_id", 16'(cmd_id), 16'd3);
        chk("hold_tflag", 16'(timeout_flag), 16'd0);
        expect_issue("hold_ack", 4'd3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
